// File: rtl/decade_pkg.sv
// Shared definitions for the cascaded decade counter: digit width, BCD limit,
// run-controller state encoding and a digit validity helper.
package decade_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Plain-vector aliases so the controller's state register stays a logic vector
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_PAUSE = PAUSE;
  localparam logic [1:0] ST_DONE  = DONE;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decade digit: counts 0..9 and wraps on inc, zeroes on reset or clr.
// at9 feeds the carry enable of the next digit up the chain.
module bcd_digit
  import decade_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             at9
);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q >= BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign at9 = (q_q == BCD_MAX);

endmodule

// File: rtl/decade_chain_ctrl.sv
// Run controller for a cascaded BCD counter: command FSM, count-tick prescaler,
// digit carry chain, latched terminal-count compare and wrap flag.
module decade_chain_ctrl
  import decade_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 10,
  parameter int DIV_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   target,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  tick,
  output logic                  done,
  output logic                  ovf
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

  logic [1:0]          state_q, state_d;
  logic [DIV_W-1:0]    presc_q, presc_d;
  logic [4*DIGITS-1:0] target_q, target_d;
  logic                ovf_q, ovf_d;

  logic [DIGITS-1:0]   at9;
  logic [DIGITS-1:0]   inc;
  logic [4*DIGITS-1:0] next_val;
  logic                all9;
  logic                tgt_ok;
  logic                hit;

  // A stop or clear in the same cycle suppresses the tick even at DIV-1
  assign tick = (state_q == ST_RUN) && !clear && !stop && (presc_q == PRESC_LAST);
  assign all9 = &at9;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign inc[k] = tick;
    end else begin : g_upper
      assign inc[k] = tick & (&at9[k-1:0]);
    end

    assign next_val[4*k +: 4] = !inc[k] ? bcd_out[4*k +: 4] :
                                at9[k]  ? 4'd0 : bcd_out[4*k +: 4] + 4'd1;

    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (inc[k]),
      .q     (bcd_out[4*k +: 4]),
      .at9   (at9[k])
    );
  end

  // Zero or any non-BCD target digit means free-run
  always_comb begin
    tgt_ok = (target_q != '0);
    for (int k = 0; k < DIGITS; k++) begin
      if (!bcd_valid(target_q[4*k +: 4])) tgt_ok = 1'b0;
    end
  end

  assign hit = tick && tgt_ok && (next_val == target_q);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    target_d = target_q;
    ovf_d    = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stop && start) begin
            state_d  = ST_RUN;
            presc_d  = '0;
            target_d = target;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + DIV_W'(1);
            ovf_d   = tick && all9;
            if (hit) state_d = ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (!stop && start) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      target_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      target_q <= target_d;
      ovf_q    <= ovf_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Bench for decade_chain_ctrl with DIGITS=2, DIV=3: directed scenarios plus a
// random command phase, all checked every cycle against an integer-count model.
module tb_decade_chain_ctrl;

  localparam int DIGITS = 2;
  localparam int DIV    = 3;
  localparam int MOD    = 100;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic                clear = 1'b0;
  logic [4*DIGITS-1:0] target = '0;
  logic [4*DIGITS-1:0] bcd_out;
  logic                running, tick, done, ovf;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  int m_state  = M_IDLE;
  int m_count  = 0;
  int m_presc  = 0;
  int m_target = 0;
  bit m_tvalid = 1'b0;
  bit m_ovf    = 1'b0;

  always #5 clk = ~clk;

  decade_chain_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .DIV_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .target  (target),
    .bcd_out (bcd_out),
    .running (running),
    .tick    (tick),
    .done    (done),
    .ovf     (ovf)
  );

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit tgt_legal(input logic [4*DIGITS-1:0] t);
    for (int d = 0; d < DIGITS; d++) begin
      if (t[4*d +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int tgt_value(input logic [4*DIGITS-1:0] t);
    int v;
    int w;
    v = 0;
    w = 1;
    for (int d = 0; d < DIGITS; d++) begin
      v = v + int'(t[4*d +: 4]) * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cyc(input bit r, input bit s, input bit p, input bit c,
                     input logic [4*DIGITS-1:0] tg);
    bit exp_tick;
    int ns, nc, np, nt;
    bit nv, no;
    rst_n  = r;
    start  = s;
    stop   = p;
    clear  = c;
    target = tg;
    #1;
    exp_tick = (m_state == M_RUN) && !c && !p && (m_presc == DIV - 1);
    if (chk_en) begin
      chk("bcd_out", 32'(bcd_out), 32'(to_bcd(m_count)));
      chk("running", 32'(running), 32'(m_state == M_RUN));
      chk("done", 32'(done), 32'(m_state == M_DONE));
      chk("tick", 32'(tick), 32'(exp_tick));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
    ns = m_state; nc = m_count; np = m_presc; nt = m_target; nv = m_tvalid; no = 1'b0;
    if (!r) begin
      ns = M_IDLE; nc = 0; np = 0; nt = 0; nv = 1'b0;
    end else if (c) begin
      ns = M_IDLE; nc = 0; np = 0;
    end else if (p) begin
      if (m_state == M_RUN) ns = M_PAUSE;
    end else if (m_state == M_IDLE && s) begin
      ns = M_RUN; np = 0; nt = tgt_value(tg); nv = tgt_legal(tg) && (tgt_value(tg) != 0);
    end else if (m_state == M_PAUSE && s) begin
      ns = M_RUN;
    end else if (m_state == M_RUN) begin
      if (m_presc == DIV - 1) begin
        np = 0;
        nc = (m_count + 1) % MOD;
        no = (m_count == MOD - 1);
        if (m_tvalid && nc == m_target) ns = M_DONE;
      end else begin
        np = m_presc + 1;
      end
    end
    @(posedge clk);
    m_state = ns; m_count = nc; m_presc = np; m_target = nt; m_tvalid = nv; m_ovf = no;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, '0);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, '0);
    chk_en = 1'b1;
    cyc(0, 0, 0, 0, '0);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_running", 32'(running), 32'h0);

    // Free run from reset
    cyc(1, 1, 0, 0, 8'h00);
    idle(30);
    chk("free_run_10", 32'(bcd_out), 32'h10);
    chk("free_run_running", 32'(running), 32'h1);

    // Terminal count at 12, hold, start ignored
    cyc(1, 0, 0, 1, '0);
    cyc(1, 1, 0, 0, 8'h12);
    for (int i = 0; i < 100 && m_state != M_DONE; i++) idle(1);
    chk("term_done", 32'(done), 32'h1);
    chk("term_bcd", 32'(bcd_out), 32'h12);
    chk("term_running", 32'(running), 32'h0);
    idle(20);
    chk("term_hold", 32'(bcd_out), 32'h12);
    cyc(1, 1, 0, 0, 8'h00);
    idle(1);
    chk("term_start_ignored", 32'(done), 32'h1);

    // Pause at 05 with prescaler at 1, resume, then start+stop together
    cyc(1, 0, 0, 1, '0);
    cyc(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 100 && !(m_state == M_RUN && m_count == 5 && m_presc == 1); i++) idle(1);
    chk("pause_at_05", 32'(bcd_out), 32'h05);
    cyc(1, 0, 1, 0, '0);
    idle(5);
    chk("pause_hold", 32'(bcd_out), 32'h05);
    chk("pause_running", 32'(running), 32'h0);
    cyc(1, 1, 0, 0, '0);
    idle(1);
    chk("resume_tick", 32'(tick), 32'h1);
    idle(4);
    cyc(1, 1, 1, 0, '0);
    chk("start_stop_pause", 32'(running), 32'h0);
    cyc(1, 1, 0, 0, '0);

    // Wrap from 99 to 00
    for (int i = 0; i < 400 && !m_ovf; i++) idle(1);
    chk("wrap_ovf", 32'(ovf), 32'h1);
    chk("wrap_bcd", 32'(bcd_out), 32'h00);
    chk("wrap_running", 32'(running), 32'h1);
    idle(1);
    chk("wrap_ovf_once", 32'(ovf), 32'h0);

    // Clear beats start at 37
    for (int i = 0; i < 400 && !(m_state == M_RUN && m_count == 37); i++) idle(1);
    chk("at_37", 32'(bcd_out), 32'h37);
    cyc(1, 1, 0, 1, 8'h00);
    chk("clear_bcd", 32'(bcd_out), 32'h00);
    chk("clear_running", 32'(running), 32'h0);
    cyc(1, 1, 0, 0, 8'h00);
    idle(3);

    // Reset while in DONE
    cyc(1, 0, 0, 1, '0);
    cyc(1, 1, 0, 0, 8'h12);
    for (int i = 0; i < 100 && m_state != M_DONE; i++) idle(1);
    chk("done_before_rst", 32'(done), 32'h1);
    cyc(0, 0, 0, 0, '0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_bcd2", 32'(bcd_out), 32'h00);
    chk("rst_ovf", 32'(ovf), 32'h0);

    // Invalid target digit: free-run through the wrap
    cyc(1, 1, 0, 0, 8'h1A);
    idle(320);
    chk("inv_tgt_done", 32'(done), 32'h0);
    chk("inv_tgt_running", 32'(running), 32'h1);

    // Random commands and targets
    for (int i = 0; i < 800; i++) begin
      bit r, s, p, c;
      logic [4*DIGITS-1:0] tg;
      r  = ($urandom_range(0, 199) != 0);
      s  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 49) == 0);
      tg = ($urandom_range(0, 1) == 0) ? to_bcd($urandom_range(1, 25)) : 8'($urandom);
      cyc(r, s, p, c, tg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
